lsu_aes_im: RTL and testbench

Load/store unit that acts as the initiator on the data-memory port of the RV32IM AES core. It accepts one load or store request at a time from the execute stage and drives the word-wide data memory, whose port is a combinational read plus a full-word write on `we = 4'b1111`. It performs the byte-lane work the memory does not: extraction and sign/zero-extension for loads, and read-modify-write for sub-word stores. Misaligned accesses are reported as errors.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 82 ++++++++
 rtl/lsu_aes_im.sv | 149 ++++++++++++++
 tb/tb_lsu_aes_im.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit and its lane aligner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (size)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane extract/extend for loads and lane
//               merge for sub-word stores (little-endian lanes).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    // Halves snap to a 2-byte boundary and words to lane 0, so an access that
    // skipped the alignment check still stays inside the addressed word.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] r;
        case (size)
            SZ_BYTE: r = off;
            SZ_HALF: r = {off[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {eff_offset(size, off), 3'b000};
        case (size)
            SZ_BYTE: r = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic [15:0] wdata
    );
        logic [4:0]  sa;
        logic [31:0] mask;
        logic [31:0] ins;
        sa = {eff_offset(size, off), 3'b000};
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << sa;
                ins  = {24'd0, wdata[7:0]} << sa;
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << sa;
                ins  = {16'd0, wdata} << sa;
            end
            default: begin
                mask = 32'd0;
                ins  = 32'd0;
            end
        endcase
        return (old_word & ~mask) | ins;
    endfunction

    assign load_data_o  = load_extract(word_i, offset_i, size_i, unsigned_i);
    assign merge_data_o = store_merge(word_i, offset_i, size_i, wdata_i);

endmodule

`default_nettype wire

// File: rtl/lsu_aes_im.sv
// ============================================================================
// Module      : lsu_aes_im
// Description : Single-outstanding load/store unit driving a word-wide data
//               memory; sub-word stores use read-modify-write.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lsu_aes_im
    import lsu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [15:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept  = req_valid && (state_q == ST_IDLE);
    assign w_req_err = (req_size == SZ_RSVD) ||
                       (CHECK_ALIGN && is_misaligned(req_size, req_addr[1:0]));

    lsu_lane_align u_lane (
        .word_i       (mem_dataout),
        .offset_i     (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .load_data_o  (w_load_data),
        .merge_data_o (w_merge_data)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = 32'd0;
        mem_we     = WE_NONE;
        mem_datain = 32'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err)                 state_d = ST_RESP;
                    else if (!req_store)           state_d = ST_LOAD;
                    else if (req_size == SZ_WORD)  state_d = ST_WRITE;
                    else                           state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                state_d  = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_we     = WE_WORD;
                mem_datain = buf_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response registers change only on the edge entering RESP, so they hold
    // from one response until the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= 16'd0;
            buf_q      <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata[15:0];
                        if (w_req_err) begin
                            rdata_q <= 32'd0;
                            err_q   <= 1'b1;
                        end else if (req_store && (req_size == SZ_WORD)) begin
                            buf_q <= req_wdata;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= w_load_data;
                    err_q   <= 1'b0;
                end
                ST_RMW_RD: begin
                    buf_q <= w_merge_data;
                end
                ST_WRITE: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_aes_im.sv
// ============================================================================
// Module      : tb_lsu_aes_im
// Description : Self-checking bench: byte-array reference memory, directed
//               cases, randomized requests and a mid-operation reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_aes_im;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [64];
    logic [7:0]  ref_b [256];
    int          wr_cnt = 0;
    int          bad_we = 0;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;

    always #5 clk = ~clk;

    lsu_aes_im #(.CHECK_ALIGN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_datain   (mem_datain),
        .mem_dataout  (mem_dataout)
    );

    assign mem_dataout = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we == 4'hF) begin
            mem[mem_addr[7:2]] <= mem_datain;
            wr_cnt  <= wr_cnt + 1;
            wr_data <= mem_datain;
            wr_addr <= mem_addr;
        end else if (mem_we != 4'h0) begin
            bad_we <= bad_we + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_b[b + 8'd3], ref_b[b + 8'd2], ref_b[b + 8'd1], ref_b[b]};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [31:0] v);
        mem[a[7:2]] = v;
        for (int k = 0; k < 4; k++) ref_b[{a[7:2], 2'b00} + 8'(k)] = v[8*k +: 8];
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] wd);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_wr, w0, n;
        logic        got;
        e_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e_rd  = 32'd0;
        e_wr  = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!st) begin
            e_lat = 2;
            if (sz == 2'b00)
                e_rd = uns ? 32'(ref_b[a]) : 32'(signed'(ref_b[a]));
            else if (sz == 2'b01)
                e_rd = uns ? 32'({ref_b[a + 8'd1], ref_b[a]})
                           : 32'(signed'({ref_b[a + 8'd1], ref_b[a]}));
            else
                e_rd = ref_word(a);
        end else begin
            e_lat = (sz == 2'b10) ? 2 : 3;
            e_wr  = 1;
            for (int k = 0; k < (1 << sz); k++) ref_b[a + 8'(k)] = wd[8*k +: 8];
        end
        w0 = wr_cnt;
        @(negedge clk);
        check("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = {24'd0, a}; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = $urandom; req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 0; got = 1'b0;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            if (resp_valid) got = 1'b1;
            else if (n < e_lat) check("ready_busy", {31'd0, req_ready}, 32'd0);
        end
        check("latency", 32'(n), 32'(e_lat));
        check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        check("resp_rdata", resp_rdata, e_rd);
        check("mem_writes", 32'(wr_cnt - w0), 32'(e_wr));
        if (st && !e_err) begin
            check("wr_data", wr_data, ref_word(a));
            check("wr_addr", wr_addr, {24'd0, a[7:2], 2'b00});
        end
        check("mem_word", mem[a[7:2]], ref_word(a));
        @(negedge clk);
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("rdata_hold", resp_rdata, e_rd);
    endtask

    initial begin
        int w0;
        logic [31:0] keep;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) poke(8'(i * 4), $urandom);
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_we", {28'd0, mem_we}, 32'd0);
        check("rst_datain", mem_datain, 32'd0);
        rst = 1'b0;

        poke(8'h10, 32'h04030201);
        poke(8'h14, 32'h080706F5);
        poke(8'h1C, 32'h100F0E0D);
        do_req(1'b0, 2'b00, 1'b0, 8'h13, 32'd0);
        do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 8'h14, 32'd0);
        do_req(1'b0, 2'b00, 1'b1, 8'h14, 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 8'h11, 32'h123456AB);
        check("sb_word", wr_data, 32'h0403AB01);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 8'h1E, 32'h0000BEEF);
        check("sh_word", wr_data, 32'hBEEF0E0D);
        do_req(1'b0, 2'b10, 1'b0, 8'h12, 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 8'h15, 32'h5555AAAA);
        do_req(1'b0, 2'b11, 1'b0, 8'h10, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 8'h20, 32'hCAFEF00D);

        for (int i = 0; i < 150; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom);

        // Reset during the read half of a byte store must drop the store.
        poke(8'h10, 32'h04030201);
        keep = 32'h04030201;
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_addr = 32'h10;
        req_wdata = 32'h000000EE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_we", {28'd0, mem_we}, 32'd0);
        check("rstmid_valid", {31'd0, resp_valid}, 32'd0);
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_hold_valid", {31'd0, resp_valid}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid_after", {31'd0, resp_valid}, 32'd0);
        check("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
        check("rstmid_writes", 32'(wr_cnt - w0), 32'd0);
        check("rstmid_mem", mem[4], keep);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);

        check("we_encoding", 32'(bad_we), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
